decoder_scan: RTL

Parametrised, registered N-to-2^N one-hot decoder with two modes: direct (decode a presented select) and scan (internally sweep the one-hot output across all 2^N lines with a programmable dwell). It is the sequential successor to the fixed 2-to-4 and 1-to-2 decoders. It drives row/column selects for multiplexed peripherals such as LED matrices, keypads and banked register enables.

---
 rtl/decoder_pkg.sv | 22 ++
 rtl/decoder_scan_if.sv | 22 ++
 rtl/decoder_n_to_onehot.sv | 18 +
 rtl/decoder_scan.sv | 127 ++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared types and sizing helpers for the decoder_scan block.
// S_BLANK is only present when DECODER_SCAN_BLANK_EN is defined.
package decoder_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIRECT = 2'd1,
        S_SCAN   = 2'd2
`ifdef DECODER_SCAN_BLANK_EN
        ,
        S_BLANK  = 2'd3
`endif
    } decoder_state_t;

    // Dwell counter width: max(1, clog2(dwell)).
    function automatic int cnt_width(input int dwell);
        int w;
        w = $clog2(dwell);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/decoder_scan_if.sv
// Select/strobe bundle between a controller and decoder_scan.
interface decoder_scan_if #(
    parameter int N = 2
) ();
    logic               ena;
    logic               mode;
    logic [N-1:0]       in;
    logic               in_valid;
    logic [(1<<N)-1:0]  out;
    logic [N-1:0]       index;
    logic               wrap;

    modport master (
        output ena, mode, in, in_valid,
        input  out, index, wrap
    );

    modport slave (
        input  ena, mode, in, in_valid,
        output out, index, wrap
    );
endinterface

// File: rtl/decoder_n_to_onehot.sv
// Combinational N-to-2^N one-hot decoder; all-zero when ena is low.
module decoder_n_to_onehot #(
    parameter int N = 2
) (
    input  logic [N-1:0]      sel,
    input  logic              ena,
    output logic [(1<<N)-1:0] onehot
);

    // Set exactly one line when enabled, none otherwise.
    always_comb begin
        onehot = '0;
        if (ena) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/decoder_scan.sv
// Registered N-to-2^N one-hot decoder with direct and scan modes.
// Optional break-before-make blank cycle between scan lines:
// define DECODER_SCAN_BLANK_EN to enable it.
module decoder_scan
    import decoder_pkg::*;
#(
    parameter int N     = 2,
    parameter int DWELL = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    decoder_scan_if.slave  bus
);

    localparam int            CW       = cnt_width(DWELL);
    localparam int            OW       = 1 << N;
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

    decoder_state_t state_q, state_d;
    logic [N-1:0]   index_q, index_d;
    logic [CW-1:0]  cnt_q,   cnt_d;
    logic           wrap_q,  wrap_d;
    logic [OW-1:0]  out_q,   out_d;
    logic [N-1:0]   idx_adv;
    logic           out_en;

    assign idx_adv = index_q + 1'b1;

    // Next-state, next-index, dwell counter and wrap pulse.
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;
        if (!bus.ena) begin
            state_d = S_IDLE;
            index_d = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) index_d = bus.in;
                    cnt_d   = '0;
                    state_d = bus.mode ? S_SCAN : S_DIRECT;
                end
                S_DIRECT: begin
                    if (bus.mode) begin
                        state_d = S_SCAN;
                        cnt_d   = '0;
                    end else if (bus.in_valid) begin
                        index_d = bus.in;
                    end
                end
                S_SCAN: begin
                    if (!bus.mode) begin
                        state_d = S_DIRECT;
                    end else if (bus.in_valid) begin
                        index_d = bus.in;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
`ifdef DECODER_SCAN_BLANK_EN
                        state_d = S_BLANK;
`else
                        index_d = idx_adv;
                        wrap_d  = (idx_adv == '0);
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`ifdef DECODER_SCAN_BLANK_EN
                S_BLANK: begin
                    cnt_d = '0;
                    if (!bus.mode) begin
                        state_d = S_DIRECT;
                        index_d = idx_adv;
                    end else if (bus.in_valid) begin
                        state_d = S_SCAN;
                        index_d = bus.in;
                    end else begin
                        state_d = S_SCAN;
                        index_d = idx_adv;
                        wrap_d  = (idx_adv == '0);
                    end
                end
`endif
                default: begin
                    state_d = S_IDLE;
                    index_d = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // A line is driven only in the states that present a selection.
    assign out_en = (state_d == S_DIRECT) || (state_d == S_SCAN);

    decoder_n_to_onehot #(.N(N)) u_dec (
        .sel    (index_d),
        .ena    (out_en),
        .onehot (out_d)
    );

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            index_q <= '0;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
            out_q   <= out_d;
        end
    end

    assign bus.out   = out_q;
    assign bus.index = index_q;
    assign bus.wrap  = wrap_q;

endmodule
